apb_req_arbiter: RTL and testbench

Two-requester APB master sequencer. It shares the single APB bus that feeds slave1/slave2 between two on-chip requesters (req0 = host port, req1 = DMA port). It arbitrates round-robin, latches the winning command, and drives the APB SETUP/ACCESS phases with PADDR[8]-based slave select. It waits on PREADY, with a timeout, and returns read data and error status to the granted requester.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_req_arbiter_rr_arb2.sv | 33 +++
 rtl/apb_req_arbiter.sv | 152 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master sequencer.
package apb_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // The top address bit selects the slave: 0 -> PSEL1, 1 -> PSEL2.
  function automatic int unsigned sel_bit(input int unsigned addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; after reset req0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 when req1 was the most recent winner
  logic r_last;

  // One-hot grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner whenever a grant is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (update && (|gnt)) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master sequencer: round-robin grant, SETUP/ACCESS
// sequencing with PREADY timeout, and a registered completion pulse.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR,
  output logic              busy
);

  localparam int unsigned SEL_BIT = sel_bit(ADDR_W);
  localparam int unsigned CNT_W   = $clog2(TIMEOUT + 1);

  state_e              r_state;
  logic                r_gid;
  logic [1:0]          r_done;
  logic [CNT_W-1:0]    r_wait;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_psel1;
  logic                r_psel2;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_busy;

  logic                w_idle;
  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_write;
  logic                w_timeout;

  // A requester is masked in its own done cycle so a stale valid is not re-served
  assign w_idle    = (r_state == ST_IDLE);
  assign w_req     = {req1_valid, req0_valid} & ~r_done & {2{w_idle}};
  assign w_addr    = w_gnt[1] ? req1_addr  : req0_addr;
  assign w_wdata   = w_gnt[1] ? req1_wdata : req0_wdata;
  assign w_write   = w_gnt[1] ? req1_write : req0_write;
  assign w_timeout = (r_wait == CNT_W'(TIMEOUT - 1));

  rr_arb2 u_rr_arb2 (
    .clk    (PCLK),
    .rst    (PRESET),
    .req    (w_req),
    .update (w_idle),
    .gnt    (w_gnt)
  );

  // Sequencer FSM with all bus and response outputs registered
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_gid       <= 1'b0;
      r_done      <= 2'b00;
      r_wait      <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_psel1     <= 1'b0;
      r_psel2     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_gid    <= w_gnt[1];
            r_paddr  <= w_addr;
            r_pwrite <= w_write;
            r_pwdata <= w_wdata;
            r_psel1  <= ~w_addr[SEL_BIT];
            r_psel2  <= w_addr[SEL_BIT];
            r_busy   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_wait    <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY || w_timeout) begin
            r_state   <= ST_IDLE;
            r_psel1   <= 1'b0;
            r_psel2   <= 1'b0;
            r_penable <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= r_gid ? 2'b10 : 2'b01;
            if (PREADY) begin
              r_rsp_err <= PSLVERR;
              if (!r_pwrite) begin
                r_rsp_rdata <= PRDATA;
              end
            end else begin
              r_rsp_err <= 1'b1;
            end
          end else begin
            r_wait <= r_wait + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_done = r_done[0];
  assign req1_done = r_done[1];
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL1     = r_psel1;
  assign PSEL2     = r_psel2;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: requester drivers, an APB slave
// model and a monitor run concurrently; expectations come from a
// transaction-level model of grant order and response rules.
module tb_apb_req_arbiter;

  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic          PCLK, PRESET;
  logic          req0_valid, req0_write, req0_done;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_write, req1_done;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL1, PSEL2, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] PRDATA;
  logic          busy;

  apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .busy(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One command plus how the slave will answer it
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    bit            tmo;
    logic [DW-1:0] prdata;
    bit            slverr;
  } cmd_t;

  typedef struct {
    int            rid;
    logic [DW-1:0] rdata;
    bit            err;
    int            lat;
    cmd_t          c;
  } exp_t;

  cmd_t cq0[$];
  cmd_t cq1[$];
  cmd_t slv_q[$];
  exp_t apb_q[$];
  exp_t exp_q[$];

  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  int            m_last = 1;
  logic [DW-1:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  function automatic cmd_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input int w, input bit t, input logic [DW-1:0] pr, input bit se);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.waits = w; c.tmo = t; c.prdata = pr; c.slverr = se;
    return c;
  endfunction

  function automatic cmd_t rnd_cmd();
    return mk(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 3)),
              ($urandom % 10) == 0, DW'($urandom), ($urandom % 4) == 0);
  endfunction

  task automatic set_req(input int rid, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (rid == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  // Present one requester's commands, holding each until its done pulse
  task automatic drive(input int rid, input bit solo);
    cmd_t q[$];
    if (rid == 0) q = cq0; else q = cq1;
    for (int k = 0; k < q.size(); k++) begin
      bit got = 0;
      bit dropped = 0;
      if (k == 0) begin
        @(negedge PCLK);
      end else if (solo && ($urandom % 2) == 1) begin
        set_req(rid, 1'b0, 1'b0, '0, '0);
        repeat ($urandom_range(1, 3)) @(negedge PCLK);
      end
      set_req(rid, 1'b1, q[k].wr, q[k].addr, q[k].wdata);
      for (int t = 0; t < 400 && !got; t++) begin
        @(posedge PCLK);
        #1;
        if ((rid == 0) ? req0_done : req1_done) begin
          got = 1;
        end else if (solo && !dropped && busy && ($urandom % 2) == 1) begin
          // Latched command must survive a dropped valid and scrambled fields
          set_req(rid, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
          dropped = 1;
        end
      end
      if (!got) flag($sformatf("done_wait_timeout_req%0d", rid));
    end
    set_req(rid, 1'b0, 1'b0, '0, '0);
  endtask

  // Predict grant order and responses, then run the drivers
  task automatic run_phase(input bit solo);
    int n0 = cq0.size();
    int n1 = cq1.size();
    int i0 = 0;
    int i1 = 0;
    while (i0 < n0 || i1 < n1) begin
      int   g;
      exp_t e;
      if (i0 < n0 && i1 < n1) g = (m_last == 0) ? 1 : 0;
      else                    g = (i0 < n0) ? 0 : 1;
      if (g == 1) begin e.c = cq1[i1]; i1++; end
      else        begin e.c = cq0[i0]; i0++; end
      m_last = g;
      e.rid  = g;
      e.err  = e.c.tmo ? 1'b1 : e.c.slverr;
      if (!e.c.tmo && !e.c.wr) m_rdata = e.c.prdata;
      e.rdata = m_rdata;
      e.lat   = e.c.tmo ? TMO + 1 : e.c.waits + 2;
      apb_q.push_back(e);
      exp_q.push_back(e);
      slv_q.push_back(e.c);
    end
    fork
      drive(0, solo);
      drive(1, solo);
    join
    for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge PCLK);
    if (exp_q.size() != 0) begin
      flag("missing_completion");
      exp_q.delete();
    end
    apb_q.delete();
    slv_q.delete();
    cq0.delete();
    cq1.delete();
  endtask

  // APB slave model and bus/response monitor
  task automatic monitor();
    cmd_t cur;
    int   acc = 0;
    int   setup_cyc = 0;
    cur = mk(1'b0, '0, '0, 0, 1'b1, '0, 1'b0);
    forever begin
      @(negedge PCLK);
      cyc++;
      if (PRESET) begin
        acc = 0;
        PREADY = 1'b0;
        continue;
      end
      chk("psel_exclusive", 32'(PSEL1 & PSEL2), 0);
      chk("penable_with_one_psel", 32'(PENABLE & ~(PSEL1 ^ PSEL2)), 0);
      chk("busy_vs_psel", 32'(busy), 32'(PSEL1 | PSEL2));
      if ((PSEL1 | PSEL2) && !PENABLE) begin
        if (apb_q.size() == 0) begin
          flag("unexpected_setup");
        end else begin
          exp_t e = apb_q.pop_front();
          chk("paddr", 32'(PADDR), 32'(e.c.addr));
          chk("pwrite", 32'(PWRITE), 32'(e.c.wr));
          chk("psel2", 32'(PSEL2), 32'(e.c.addr[AW-1]));
          if (e.c.wr) chk("pwdata", 32'(PWDATA), 32'(e.c.wdata));
          setup_cyc = cyc;
        end
      end
      if (req0_done | req1_done) begin
        chk("done_onehot", 32'(req0_done & req1_done), 0);
        if (exp_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          exp_t e = exp_q.pop_front();
          chk("done_requester", 32'(req1_done), 32'(e.rid));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          chk("setup_to_done_cycles", 32'(cyc - setup_cyc), 32'(e.lat));
        end
      end
      if ((PSEL1 | PSEL2) && PENABLE) begin
        if (acc == 0) begin
          if (slv_q.size() == 0) begin
            flag("slave_queue_empty");
            cur = mk(1'b0, '0, '0, 0, 1'b1, '0, 1'b0);
          end else begin
            cur = slv_q.pop_front();
          end
        end
        PREADY  = !cur.tmo && (acc >= cur.waits);
        PRDATA  = PREADY ? cur.prdata : DW'($urandom);
        PSLVERR = PREADY ? cur.slverr : 1'($urandom);
        acc++;
      end else begin
        acc     = 0;
        PREADY  = 1'($urandom);
        PRDATA  = DW'($urandom);
        PSLVERR = 1'($urandom);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel1"}, 32'(PSEL1), 0);
    chk({tag, "_psel2"}, 32'(PSEL2), 0);
    chk({tag, "_penable"}, 32'(PENABLE), 0);
    chk({tag, "_pwrite"}, 32'(PWRITE), 0);
    chk({tag, "_paddr"}, 32'(PADDR), 0);
    chk({tag, "_pwdata"}, 32'(PWDATA), 0);
    chk({tag, "_done"}, 32'({req1_done, req0_done}), 0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    bit aborted_seen;
    PRESET = 1'b1;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    fork
      monitor();
    join_none
    repeat (2) @(negedge PCLK);
    chk_all_zero("reset");
    PRESET = 1'b0;

    // Single write to slave1, immediate ready
    cq0.push_back(mk(1'b1, 9'h005, 8'hA5, 0, 1'b0, 8'h00, 1'b0));
    run_phase(1'b1);
    // Read from slave2 with two wait states
    cq1.push_back(mk(1'b0, 9'h105, 8'h00, 2, 1'b0, 8'h3C, 1'b0));
    run_phase(1'b1);
    // Contention: both held for two commands each, grants alternate 0,1,0,1
    for (int k = 0; k < 2; k++) begin
      cq0.push_back(rnd_cmd());
      cq1.push_back(rnd_cmd());
    end
    run_phase(1'b0);
    // PREADY never rises: forced error completion
    cq0.push_back(mk(1'b0, 9'h033, 8'h00, 0, 1'b1, 8'h00, 1'b0));
    run_phase(1'b1);
    // Slave error on a write at the top address
    cq1.push_back(mk(1'b1, 9'h1FF, 8'h5A, 0, 1'b0, 8'h00, 1'b1));
    run_phase(1'b1);

    // Asynchronous reset while the slave is inserting wait states
    begin
      exp_t e;
      e.c = mk(1'b0, 9'h0AA, 8'h00, 0, 1'b1, 8'h00, 1'b0);
      e.rid = 0; e.rdata = '0; e.err = 1'b0; e.lat = 0;
      apb_q.push_back(e);
      slv_q.push_back(e.c);
      @(negedge PCLK);
      set_req(0, 1'b1, 1'b0, 9'h0AA, 8'h00);
      for (int t = 0; t < 20 && !PENABLE; t++) @(negedge PCLK);
      chk("reached_access", 32'(PENABLE), 1);
      repeat (3) @(negedge PCLK);
      #2;
      PRESET = 1'b1;
      #1;
      chk_all_zero("async_reset");
      set_req(0, 1'b0, 1'b0, '0, '0);
      aborted_seen = 0;
      repeat (3) begin
        @(posedge PCLK);
        #1;
        if (req0_done | req1_done) aborted_seen = 1;
      end
      chk("no_done_after_abort", 32'(aborted_seen), 0);
      apb_q.delete();
      slv_q.delete();
      m_last  = 1;
      m_rdata = '0;
      @(negedge PCLK);
      PRESET = 1'b0;
      repeat (2) @(negedge PCLK);
    end
    // After reset req0 must win the first tie
    cq0.push_back(mk(1'b1, 9'h011, 8'h11, 1, 1'b0, 8'h00, 1'b0));
    cq1.push_back(mk(1'b1, 9'h122, 8'h22, 0, 1'b0, 8'h00, 1'b0));
    run_phase(1'b0);

    // Randomized phases: solo requester 0, solo requester 1, or contention
    for (int p = 0; p < 12; p++) begin
      int mode = int'($urandom_range(0, 2));
      int n    = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        if (mode != 1) cq0.push_back(rnd_cmd());
        if (mode != 0) cq1.push_back(rnd_cmd());
      end
      if (mode == 2 && ($urandom % 2) == 1) cq1.push_back(rnd_cmd());
      run_phase(mode != 2);
    end

    repeat (3) @(negedge PCLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
